// File: rtl/piso_serializer_pkg.sv
// Shared std_module library package: FSM state encoding and a constant clog2 helper.
package std_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first, OUT_LAST on the final frame bit.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import std_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] IN0,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT0,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  state_t                 state, state_nx;
  logic [FRAME_LEN-1:0]   sreg, sreg_nx, load;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   last, accept, consume;

`ifdef PISO_PARITY_EN
  assign load = {^IN0, IN0};
`else
  assign load = IN0;
`endif

  // Counter is only meaningful in SHIFT; gating by state keeps OUT_LAST low in IDLE.
  assign last      = (state == ST_SHIFT) && (cnt == LAST_CNT);
  assign OUT_VALID = (state == ST_SHIFT);
  assign OUT0      = sreg[0];
  assign OUT_LAST  = last;
  assign IN_READY  = (state == ST_IDLE) | (last & OUT_READY);
  assign accept    = IN_VALID & IN_READY;
  assign consume   = OUT_VALID & OUT_READY;

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    if (consume) begin
      sreg_nx = sreg >> 1;
      if (last) state_nx = ST_IDLE;
      else      cnt_nx   = cnt + CW'(1);
    end
    // A load on the last-bit edge overrides the drop to IDLE for gapless frames.
    if (accept) begin
      sreg_nx  = load;
      cnt_nx   = '0;
      state_nx = ST_SHIFT;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer; honours PISO_PARITY_EN when defined.
module tb_piso_serializer;
  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             CLK = 1'b0;
  logic             RSTn;
  logic [WIDTH-1:0] IN0;
  logic             IN_VALID;
  logic             IN_READY;
  logic             OUT0;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_LAST;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .IN0      (IN0),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OUT0     (OUT0),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_LAST (OUT_LAST)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic d;
    logic l;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  bp = 1'b0;
  logic  hold_pend = 1'b0;
  logic  hold_d, hold_l;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Expected bit stream for one accepted word, LSB first, optional even parity.
  task automatic push_word(input logic [WIDTH-1:0] w);
    beat_t b;
    for (int i = 0; i < WIDTH; i++) begin
      b.d = w[i];
      b.l = (i == FRAME_LEN - 1);
      sb.push_back(b);
    end
    if (FRAME_LEN > WIDTH) begin
      b.d = ^w;
      b.l = 1'b1;
      sb.push_back(b);
    end
  endtask

  always @(negedge CLK) begin
    beat_t e;
    if (!RSTn) begin
      sb.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_out0", OUT0, hold_d);
        check("hold_last", OUT_LAST, hold_l);
      end
      hold_pend = OUT_VALID && !OUT_READY;
      hold_d    = OUT0;
      hold_l    = OUT_LAST;
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) check("spurious_bit", 1, 0);
        else begin
          e = sb.pop_front();
          check("out0", OUT0, e.d);
          check("out_last", OUT_LAST, e.l);
        end
      end
      if (IN_VALID && IN_READY) push_word(IN0);
    end
  end

  always @(posedge CLK) if (bp) #1 OUT_READY = ~OUT_READY;

  task automatic send(input logic [WIDTH-1:0] w);
    bit done;
    done = 0;
    IN0 = w;
    IN_VALID = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        IN0 = ~w;
        done = 1;
      end
    end
    check("send_timeout", done, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK);
      #2;
      if (sb.size() == 0 && !OUT_VALID) done = 1;
    end
    check("drain_timeout", done, 1);
  endtask

  initial begin
    RSTn = 1'b0;
    IN0 = '0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_last", OUT_LAST, 0);
    check("rst_out0", OUT0, 0);
    check("rst_in_ready", IN_READY, 1);

    // Single frame with IN_READY profile
    @(posedge CLK); #1;
    send(8'hA5);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge CLK);
      check("frame_valid", OUT_VALID, 1);
      check("frame_in_ready", IN_READY, (i == FRAME_LEN - 1));
    end
    wait_drain();

    // Backpressure
    bp = 1'b1;
    send(8'h3C);
    wait_drain();
    bp = 1'b0;
    @(posedge CLK); #1 OUT_READY = 1'b1;

    // Back-to-back frames with no bubble
    send(8'hFF);
    fork
      send(8'h00);
      for (int i = 0; i < 2 * FRAME_LEN; i++) begin
        @(negedge CLK);
        check("b2b_valid", OUT_VALID, 1);
      end
    join
    wait_drain();

    // Reset mid-frame
    send(8'hF0);
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1 RSTn = 1'b0;
    @(posedge CLK); #1 RSTn = 1'b1;
    @(negedge CLK);
    check("midrst_valid", OUT_VALID, 0);
    check("midrst_out0", OUT0, 0);
    check("midrst_in_ready", IN_READY, 1);
    send(8'h01);
    wait_drain();

    // Parity example word (plain 8 bits when parity is disabled)
    send(8'h07);
    wait_drain();

    // Random words with random backpressure
    for (int n = 0; n < 6; n++) begin
      bp = $urandom_range(0, 1);
      send(WIDTH'($urandom));
      wait_drain();
      bp = 1'b0;
      @(posedge CLK); #1 OUT_READY = 1'b1;
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter for the std_module library. It is the transmit end of the planned sipo_deserializer receiver.
- Accepts one WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per accepted output beat.
- Marks the last bit of each frame with OUT_LAST.
- Sits between a parallel producer and a bit-serial link or consumer.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..64.

Ports:
- CLK  input  1  clock; all logic is rising-edge.
- RSTn  input  1  synchronous, active-low reset.
- IN0  input  WIDTH  parallel data word.
- IN_VALID  input  1  IN0 holds a valid word.
- IN_READY  output  1  block can accept a word this cycle.
- OUT0  output  1  serial data bit.
- OUT_VALID  output  1  OUT0 is valid.
- OUT_READY  input  1  consumer accepts OUT0 this cycle.
- OUT_LAST  output  1  OUT0 is the final bit of the frame.

Behaviour:
- Reset: applied when RSTn=0 at a CLK edge.
  - State goes to IDLE. Shift register and bit counter clear to 0.
  - After that edge: OUT0=0, OUT_VALID=0, OUT_LAST=0, IN_READY=1.
  - Reset mid-frame discards the frame. No partial bits are emitted after reset.
- States:
  - IDLE: OUT_VALID=0, IN_READY=1.
  - SHIFT: OUT_VALID=1.
- Input handshake: a word is accepted on a CLK edge where IN_VALID&IN_READY=1.
  - The word is loaded into the shift register and the counter is set to 0.
  - State goes to SHIFT.
- Output handshake: a bit is consumed on an edge where OUT_VALID&OUT_READY=1.
  - On consumption the register shifts right by 1 and the counter increments.
  - With OUT_READY=0, OUT0, OUT_LAST and the internal state hold unchanged.
- OUT0 = shift register bit 0, registered.
- Latency: bit 0 appears on OUT0 in the cycle after the accepting edge.
- OUT_LAST=1 exactly when counter = FRAME_LEN-1, with FRAME_LEN=WIDTH (WIDTH+1 with parity).
- IN_READY = (state==IDLE) | (state==SHIFT & OUT_LAST & OUT_READY).
  - This gives back-to-back frames with no idle bubble.
- Consumption of the last bit:
  - If IN_VALID=1 on the same edge, the new word loads and the block stays in SHIFT.
  - Otherwise the block goes to IDLE.
- Counter width is clog2(WIDTH+1). The counter never wraps: it is reloaded on accept and idle in IDLE.
- IN0 is sampled only on the accepting edge. Later changes to IN0 have no effect.
- IN_VALID while in SHIFT and not on the last bit: ignored (IN_READY=0). The producer must hold it.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - A parity bit is appended after the data, so FRAME_LEN=WIDTH+1.
  - Parity bit = XOR of the accepted word (even parity), computed at load.
  - OUT_LAST is asserted on the parity bit only.
- Undefined: FRAME_LEN=WIDTH, no parity logic, and OUT_LAST is asserted on data bit WIDTH-1.

Decomposition:
- Shared package std_pkg holds:
  - the state enum (ST_IDLE=1'b0, ST_SHIFT=1'b1);
  - a clog2 constant function.
- No sub-module. Counter and shift register are inline.
- The parity XOR reduction may reuse the library's basic gates; this is not required.

Test Plan:
- Reset then idle: hold RSTn=0 for 2 cycles, then release → OUT_VALID=0, OUT_LAST=0, OUT0=0, IN_READY=1.
- Single frame, WIDTH=8: IN0=8'hA5, pulse IN_VALID, OUT_READY=1 → OUT0 sequence 1,0,1,0,0,1,0,1 over 8 consecutive cycles. OUT_LAST high only on the 8th. IN_READY=0 during bits 1-7.
- Backpressure: IN0=8'h3C, toggle OUT_READY 1,0,1,0… → each bit is held while OUT_READY=0. The sequence matches 0,0,1,1,1,1,0,0 with no bit lost or duplicated.
- Back-to-back: IN_VALID held high with 8'hFF then 8'h00 → 16 contiguous OUT_VALID cycles, eight 1s then eight 0s. OUT_LAST pulses on cycles 8 and 16.
- Reset mid-frame: accept 8'hF0, assert RSTn=0 after 3 bits → OUT_VALID=0 after the reset edge. The next frame 8'h01 emits 1 followed by seven 0s.
- PISO_PARITY_EN defined, IN0=8'h07 → 9 bits 1,1,1,0,0,0,0,0,1. OUT_LAST is asserted on the 9th bit only.
